// File: rtl/axis_pkt_arbiter.sv
// Two-requester AXI-Stream packet arbiter with round-robin tie break.
// Whole packets are granted; the processor configuration is captured per grant.
module axis_pkt_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTES      = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [1:0]            mode0,
    input  logic [1:0]            mode1,
    input  logic [DATA_WIDTH-1:0] add_value0,
    input  logic [DATA_WIDTH-1:0] add_value1,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    input  logic [BYTES-1:0]      s0_axis_tkeep,
    input  logic [BYTES-1:0]      s0_axis_tstrb,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_tready,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    input  logic [BYTES-1:0]      s1_axis_tkeep,
    input  logic [BYTES-1:0]      s1_axis_tstrb,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic [BYTES-1:0]      m_axis_tkeep,
    output logic [BYTES-1:0]      m_axis_tstrb,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [1:0]            mode_out,
    output logic [DATA_WIDTH-1:0] add_value_out,
    output logic [1:0]            grant,
    output logic [CNT_WIDTH-1:0]  pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic [1:0]              mode_out_q, mode_out_d;
    logic [DATA_WIDTH-1:0]   add_value_out_q, add_value_out_d;
    logic [CNT_WIDTH-1:0]    pkt_cnt0_q, pkt_cnt0_d;
    logic [CNT_WIDTH-1:0]    pkt_cnt1_q, pkt_cnt1_d;
    logic                    pkt_done;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q         <= IDLE;
            last_grant_q    <= 1'b1;
            mode_out_q      <= '0;
            add_value_out_q <= '0;
            pkt_cnt0_q      <= '0;
            pkt_cnt1_q      <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            mode_out_q      <= mode_out_d;
            add_value_out_q <= add_value_out_d;
            pkt_cnt0_q      <= pkt_cnt0_d;
            pkt_cnt1_q      <= pkt_cnt1_d;
        end
    end

    // Owner's stream is routed straight through; everything is quiet when idle.
    always_comb begin
        m_axis_tdata   = '0;
        m_axis_tvalid  = 1'b0;
        m_axis_tkeep   = '0;
        m_axis_tstrb   = '0;
        m_axis_tlast   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        grant          = 2'b00;
        case (state_q)
            BUSY0: begin
                m_axis_tdata   = s0_axis_tdata;
                m_axis_tvalid  = s0_axis_tvalid;
                m_axis_tkeep   = s0_axis_tkeep;
                m_axis_tstrb   = s0_axis_tstrb;
                m_axis_tlast   = s0_axis_tlast;
                s0_axis_tready = m_axis_tready;
                grant          = 2'b01;
            end
            BUSY1: begin
                m_axis_tdata   = s1_axis_tdata;
                m_axis_tvalid  = s1_axis_tvalid;
                m_axis_tkeep   = s1_axis_tkeep;
                m_axis_tstrb   = s1_axis_tstrb;
                m_axis_tlast   = s1_axis_tlast;
                s1_axis_tready = m_axis_tready;
                grant          = 2'b10;
            end
            default: ;
        endcase
    end

    assign pkt_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        mode_out_d      = mode_out_q;
        add_value_out_d = add_value_out_q;
        pkt_cnt0_d      = pkt_cnt0_q;
        pkt_cnt1_d      = pkt_cnt1_q;
        case (state_q)
            IDLE: begin
                // On a tie, the requester that did not own the last packet wins.
                if (s0_axis_tvalid && (!s1_axis_tvalid || last_grant_q)) begin
                    state_d         = BUSY0;
                    mode_out_d      = mode0;
                    add_value_out_d = add_value0;
                end else if (s1_axis_tvalid) begin
                    state_d         = BUSY1;
                    mode_out_d      = mode1;
                    add_value_out_d = add_value1;
                end
            end
            BUSY0: begin
                if (pkt_done) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                    pkt_cnt0_d   = pkt_cnt0_q + CNT_WIDTH'(1);
                end
            end
            BUSY1: begin
                if (pkt_done) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                    pkt_cnt1_d   = pkt_cnt1_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mode_out      = mode_out_q;
    assign add_value_out = add_value_out_q;
    assign pkt_cnt0      = pkt_cnt0_q;
    assign pkt_cnt1      = pkt_cnt1_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Randomized bench for axis_pkt_arbiter: drivers queue expected beats per requester,
// a monitor checks routing, grant rules, configuration capture and packet counts.
module tb_axis_pkt_arbiter;

    localparam int DW  = 32;
    localparam int BY  = DW / 8;
    localparam int CW  = 8;
    localparam int TMO = 2000;

    typedef struct {
        logic [DW-1:0] data;
        logic [BY-1:0] keep;
        logic [BY-1:0] strb;
        logic          last;
        logic [1:0]    mode;
        logic [DW-1:0] addv;
    } beat_t;

    logic          clk, areset;
    logic [1:0]    mode0, mode1;
    logic [DW-1:0] add_value0, add_value1;
    logic [DW-1:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
    logic          s0_axis_tvalid, s1_axis_tvalid, m_axis_tvalid;
    logic [BY-1:0] s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
    logic [BY-1:0] s0_axis_tstrb, s1_axis_tstrb, m_axis_tstrb;
    logic          s0_axis_tlast, s1_axis_tlast, m_axis_tlast;
    logic          s0_axis_tready, s1_axis_tready, m_axis_tready;
    logic [1:0]    mode_out, grant;
    logic [DW-1:0] add_value_out;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1;

    axis_pkt_arbiter #(.DATA_WIDTH(DW), .BYTES(BY), .CNT_WIDTH(CW)) dut (
        .aclk(clk), .areset(areset),
        .mode0(mode0), .mode1(mode1), .add_value0(add_value0), .add_value1(add_value1),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid),
        .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tstrb(s0_axis_tstrb),
        .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid),
        .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tstrb(s1_axis_tstrb),
        .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tstrb(m_axis_tstrb),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .mode_out(mode_out), .add_value_out(add_value_out), .grant(grant),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    errors, checks, rdy_pct;
    logic  mon_en;
    beat_t exp_q0[$], exp_q1[$];
    logic [1:0] gseq[$];

    task automatic check(input bit cond, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!cond) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic set_cfg(input int who, input logic [1:0] md, input logic [DW-1:0] av);
        if (who == 0) begin mode0 = md; add_value0 = av; end
        else begin mode1 = md; add_value1 = av; end
    endtask

    task automatic drive_beat(input int who, input beat_t b);
        if (who == 0) begin
            s0_axis_tvalid = 1'b1; s0_axis_tdata = b.data; s0_axis_tkeep = b.keep;
            s0_axis_tstrb = b.strb; s0_axis_tlast = b.last;
        end else begin
            s1_axis_tvalid = 1'b1; s1_axis_tdata = b.data; s1_axis_tkeep = b.keep;
            s1_axis_tstrb = b.strb; s1_axis_tlast = b.last;
        end
    endtask

    task automatic drive_idle(input int who);
        if (who == 0) begin
            s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tkeep = '0;
            s0_axis_tstrb = '0; s0_axis_tlast = 1'b0;
        end else begin
            s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tkeep = '0;
            s1_axis_tstrb = '0; s1_axis_tlast = 1'b0;
        end
    endtask

    // Returns just after the edge on which the presented beat was taken.
    task automatic wait_accept(input int who);
        int n = 0;
        @(negedge clk);
        while (!((who == 0) ? s0_axis_tready : s1_axis_tready)) begin
            n++;
            if (n > TMO) begin
                check(1'b0, "accept_timeout", who, 1);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk); #2;
    endtask

    task automatic send_pkt(input int who, input int len, input int gap_pct,
                            input logic [1:0] md, input logic [DW-1:0] av);
        beat_t b;
        set_cfg(who, md, av);
        for (int i = 0; i < len; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                drive_idle(who);
                @(posedge clk); #2;
            end
            b.data = $urandom;
            b.keep = BY'($urandom);
            b.strb = BY'($urandom);
            b.last = (i == len - 1);
            b.mode = md;
            b.addv = av;
            if (who == 0) exp_q0.push_back(b); else exp_q1.push_back(b);
            drive_beat(who, b);
            wait_accept(who);
            // The captured configuration must not follow later input changes.
            if (i == 0) set_cfg(who, ~md, ~av);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < TMO) begin
            @(posedge clk);
            n++;
        end
        if (n >= TMO) check(1'b0, "drain_timeout", exp_q0.size() + exp_q1.size(), 0);
        @(posedge clk); #2;
    endtask

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk); #2;
            m_axis_tready = ($urandom_range(99) < rdy_pct);
        end
    end

    // Reference model state: last owner, packet counts, and previous-cycle observations.
    logic          m_last, prev_ok, have, p_hs_last;
    logic [CW-1:0] cnt_m0, cnt_m1;
    logic [1:0]    p_grant, g_rec, eg, exp_rdy;
    logic          p_v0, p_v1, p_mv, p_mr, p_tlast;
    logic [DW-1:0] p_data, src_data;
    logic [BY-1:0] p_keep, p_strb;
    logic          src_ok;
    beat_t         expb;

    always @(negedge clk) begin
        if (!mon_en) begin
            cnt_m0 = '0; cnt_m1 = '0; m_last = 1'b1; prev_ok = 1'b0; g_rec = 2'b00;
            gseq.delete(); exp_q0.delete(); exp_q1.delete();
        end else begin
            if (prev_ok) begin
                if (p_grant == 2'b00) begin
                    if (p_v0 && p_v1)  eg = m_last ? 2'b01 : 2'b10;
                    else if (p_v0)     eg = 2'b01;
                    else if (p_v1)     eg = 2'b10;
                    else               eg = 2'b00;
                end else if (p_hs_last) eg = 2'b00;
                else                    eg = p_grant;
                check(grant == eg, "grant", grant, eg);
                if (p_grant != 2'b00 && grant == p_grant && p_mv && !p_mr)
                    check(m_axis_tvalid && m_axis_tdata == p_data && m_axis_tkeep == p_keep &&
                          m_axis_tstrb == p_strb && m_axis_tlast == p_tlast,
                          "stall_hold", m_axis_tdata, p_data);
            end
            exp_rdy  = 2'b00;
            src_ok   = 1'b0;
            src_data = '0;
            case (grant)
                2'b00: src_ok = !m_axis_tvalid && m_axis_tdata == '0 && m_axis_tkeep == '0 &&
                                m_axis_tstrb == '0 && !m_axis_tlast;
                2'b01: begin
                    exp_rdy  = {1'b0, m_axis_tready};
                    src_data = s0_axis_tdata;
                    src_ok   = m_axis_tvalid == s0_axis_tvalid && m_axis_tdata == s0_axis_tdata &&
                               m_axis_tkeep == s0_axis_tkeep && m_axis_tstrb == s0_axis_tstrb &&
                               m_axis_tlast == s0_axis_tlast;
                end
                2'b10: begin
                    exp_rdy  = {m_axis_tready, 1'b0};
                    src_data = s1_axis_tdata;
                    src_ok   = m_axis_tvalid == s1_axis_tvalid && m_axis_tdata == s1_axis_tdata &&
                               m_axis_tkeep == s1_axis_tkeep && m_axis_tstrb == s1_axis_tstrb &&
                               m_axis_tlast == s1_axis_tlast;
                end
                default: src_ok = 1'b0;
            endcase
            check(src_ok, "m_axis_route", m_axis_tdata, src_data);
            check({s1_axis_tready, s0_axis_tready} == exp_rdy, "tready", {s1_axis_tready, s0_axis_tready}, exp_rdy);
            check(pkt_cnt0 == cnt_m0, "pkt_cnt0", pkt_cnt0, cnt_m0);
            check(pkt_cnt1 == cnt_m1, "pkt_cnt1", pkt_cnt1, cnt_m1);
            have = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                if (grant == 2'b01 && exp_q0.size() != 0) begin expb = exp_q0.pop_front(); have = 1'b1; end
                else if (grant == 2'b10 && exp_q1.size() != 0) begin expb = exp_q1.pop_front(); have = 1'b1; end
                check(have, "unexpected_beat", grant, 0);
                if (have) begin
                    check(m_axis_tdata == expb.data, "tdata", m_axis_tdata, expb.data);
                    check(m_axis_tkeep == expb.keep && m_axis_tstrb == expb.strb, "tkeep_tstrb",
                          {m_axis_tkeep, m_axis_tstrb}, {expb.keep, expb.strb});
                    check(m_axis_tlast == expb.last, "tlast", m_axis_tlast, expb.last);
                    check(mode_out == expb.mode, "mode_out", mode_out, expb.mode);
                    check(add_value_out == expb.addv, "add_value_out", add_value_out, expb.addv);
                    if (expb.last) begin
                        if (grant == 2'b01) begin cnt_m0 = cnt_m0 + 1'b1; m_last = 1'b0; end
                        else begin cnt_m1 = cnt_m1 + 1'b1; m_last = 1'b1; end
                    end
                end
            end
            p_hs_last = have && expb.last;
            if (grant != g_rec) begin gseq.push_back(grant); g_rec = grant; end
            p_grant = grant; p_v0 = s0_axis_tvalid; p_v1 = s1_axis_tvalid;
            p_mv = m_axis_tvalid; p_mr = m_axis_tready; p_data = m_axis_tdata;
            p_keep = m_axis_tkeep; p_strb = m_axis_tstrb; p_tlast = m_axis_tlast;
            prev_ok = 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    beat_t         rb;
    logic [1:0]    exp_g[5];
    logic [CW-1:0] ones;

    initial begin
        errors = 0; checks = 0; rdy_pct = 100; mon_en = 1'b0; areset = 1'b1;
        ones = '1;
        exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        set_cfg(0, 2'd1, 32'h11); set_cfg(1, 2'd2, 32'h22);
        rb.data = 32'hA5A5_0001; rb.keep = '1; rb.strb = '1; rb.last = 1'b0;
        drive_beat(0, rb); drive_beat(1, rb);

        // Reset held with both requesters valid.
        repeat (3) begin
            @(negedge clk);
            check(grant == 2'b00, "rst_grant", grant, 0);
            check(!m_axis_tvalid, "rst_tvalid", m_axis_tvalid, 0);
            check({s1_axis_tready, s0_axis_tready} == 2'b00, "rst_tready", {s1_axis_tready, s0_axis_tready}, 0);
            check(pkt_cnt0 == 0 && pkt_cnt1 == 0, "rst_cnt", {pkt_cnt1, pkt_cnt0}, 0);
            check(mode_out == 0 && add_value_out == 0, "rst_cfg", add_value_out, 0);
        end
        @(posedge clk); #2;
        areset = 1'b0; drive_idle(0); drive_idle(1);
        @(posedge clk); #2;
        mon_en = 1'b1;

        // Continuous 2-beat packets on both: round-robin sequence.
        fork
            begin send_pkt(0, 2, 0, 2'($urandom), $urandom); send_pkt(0, 2, 0, 2'($urandom), $urandom); drive_idle(0); end
            begin send_pkt(1, 2, 0, 2'($urandom), $urandom); send_pkt(1, 2, 0, 2'($urandom), $urandom); drive_idle(1); end
        join
        wait_drain();
        check(gseq.size() >= 5, "gseq_len", gseq.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < gseq.size()) check(gseq[i] == exp_g[i], "gseq", gseq[i], exp_g[i]);

        // Configuration changes mid-packet must not reach mode_out/add_value_out.
        send_pkt(0, 3, 0, 2'd2, 32'd5);
        drive_idle(0);
        wait_drain();

        // Downstream stall in the middle of an s1 packet while s0 waits.
        fork
            begin send_pkt(1, 4, 0, 2'($urandom), $urandom); drive_idle(1); end
            begin repeat (2) @(posedge clk); #2; send_pkt(0, 2, 0, 2'($urandom), $urandom); drive_idle(0); end
            begin repeat (3) @(posedge clk); rdy_pct = 0; repeat (4) @(posedge clk); rdy_pct = 100; end
        join
        wait_drain();

        // s0 drops tvalid inside its packet while s1 is waiting.
        fork
            begin send_pkt(0, 4, 60, 2'($urandom), $urandom); drive_idle(0); end
            begin @(posedge clk); #2; send_pkt(1, 2, 0, 2'($urandom), $urandom); drive_idle(1); end
        join
        wait_drain();

        // Random traffic with random backpressure.
        rdy_pct = 70;
        fork
            begin repeat (30) send_pkt(0, $urandom_range(1, 5), 25, 2'($urandom), $urandom); drive_idle(0); end
            begin repeat (30) send_pkt(1, $urandom_range(1, 5), 25, 2'($urandom), $urandom); drive_idle(1); end
        join
        wait_drain();
        rdy_pct = 100;
        repeat (2) @(posedge clk); #2;

        // Reset on beat 2 of a 4-beat s0 packet; the rest becomes a new packet.
        mon_en = 1'b0;
        set_cfg(0, 2'd3, 32'h77);
        rb.data = 32'd1; rb.last = 1'b0; drive_beat(0, rb);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rb.data = 32'd2; drive_beat(0, rb); areset = 1'b1;
        @(posedge clk); #2;
        areset = 1'b0; rb.data = 32'd3; drive_beat(0, rb);
        @(negedge clk);
        check(grant == 2'b00, "midrst_grant", grant, 0);
        check(!m_axis_tvalid, "midrst_tvalid", m_axis_tvalid, 0);
        check(!s0_axis_tready, "midrst_tready", s0_axis_tready, 0);
        check(pkt_cnt0 == 0 && pkt_cnt1 == 0, "midrst_cnt", {pkt_cnt1, pkt_cnt0}, 0);
        check(mode_out == 0 && add_value_out == 0, "midrst_cfg", add_value_out, 0);
        @(posedge clk); #2;
        @(negedge clk);
        check(grant == 2'b01, "regrant", grant, 1);
        check(m_axis_tdata == 32'd3, "regrant_data", m_axis_tdata, 3);
        check(mode_out == 2'd3 && add_value_out == 32'h77, "regrant_cfg", add_value_out, 32'h77);
        @(posedge clk); #2;
        rb.data = 32'd4; rb.last = 1'b1; drive_beat(0, rb);
        @(posedge clk); #2;
        drive_idle(0);
        @(negedge clk);
        check(pkt_cnt0 == 1, "regrant_cnt", pkt_cnt0, 1);
        check(grant == 2'b00, "regrant_idle", grant, 0);

        // Counter wrap from all-ones to zero.
        @(posedge clk); #2; areset = 1'b1;
        @(posedge clk); #2; areset = 1'b0;
        @(posedge clk); #2; mon_en = 1'b1;
        for (int i = 0; i < (1 << CW) - 1; i++) send_pkt(0, 1, 0, 2'($urandom), $urandom);
        drive_idle(0);
        wait_drain();
        @(negedge clk);
        check(pkt_cnt0 == ones, "cnt_all_ones", pkt_cnt0, ones);
        @(posedge clk); #2;
        send_pkt(0, 1, 0, 2'($urandom), $urandom);
        drive_idle(0);
        wait_drain();
        @(negedge clk);
        check(pkt_cnt0 == 0, "cnt_wrap", pkt_cnt0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_pkt_arbiter.md
AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the stream data width (32 or 64).
REQ-002 Parameter BYTES, default DATA_WIDTH/8, SHALL set the tkeep/tstrb width.
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set the width of each packet counter.
REQ-004 aclk  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 areset  in  1  SHALL be a synchronous, active-high reset.
REQ-006 mode0, mode1  in  2 each  SHALL be the processor mode for requester 0/1.
REQ-007 add_value0, add_value1  in  DATA_WIDTH each  SHALL be the add constant for requester 0/1.
REQ-008 s0_axis_tdata/tvalid/tkeep/tstrb/tlast  in  DATA_WIDTH/1/BYTES/BYTES/1  SHALL be requester 0's stream.
REQ-009 s0_axis_tready  out  1  SHALL be requester 0's ready.
REQ-010 s1_axis_* and s1_axis_tready SHALL mirror REQ-008/REQ-009 for requester 1.
REQ-011 m_axis_tdata/tvalid/tkeep/tstrb/tlast  out  DATA_WIDTH/1/BYTES/BYTES/1  SHALL be the arbitrated stream to the processor.
REQ-012 m_axis_tready  in  1  SHALL be downstream ready; integration ties it to processor FIFO not-full.
REQ-013 mode_out  out  2; add_value_out  out  DATA_WIDTH  SHALL be the processor configuration for the granted packet.
REQ-014 grant  out  2  SHALL be one-hot owner: 01 = requester 0, 10 = requester 1, 00 = none.
REQ-015 pkt_cnt0, pkt_cnt1  out  CNT_WIDTH each  SHALL count completed packets per requester.

Function
REQ-016 States SHALL be IDLE, BUSY0 and BUSY1, held in a register.
REQ-017 IDLE, exactly one sN_axis_tvalid high -> BUSYN on the next edge.
REQ-018 IDLE, both tvalid high -> the grant SHALL go to the requester not equal to last_grant (round-robin).
REQ-019 IDLE, neither tvalid high -> remain IDLE.
REQ-020 On entering BUSYN, modeN/add_valueN SHALL be latched into mode_out/add_value_out, which SHALL hold constant until the state returns to IDLE.
REQ-021 In BUSYN, m_axis_tdata/tvalid/tkeep/tstrb/tlast SHALL combinationally equal sN's signals; sN_axis_tready SHALL equal m_axis_tready; the other requester's tready SHALL be 0.
REQ-022 In IDLE, m_axis_tvalid, both trdy outputs, m_axis_tdata/tkeep/tstrb/tlast and grant SHALL be 0.
REQ-023 In BUSYN, a handshake (m_axis_tvalid & m_axis_tready & m_axis_tlast) SHALL move the state to IDLE, set last_grant to N and increment pkt_cntN on the same edge.
REQ-024 pkt_cntN SHALL wrap from all-ones to 0.
REQ-025 In BUSYN, sN_axis_tvalid falling mid-packet SHALL NOT release the grant; the state SHALL wait in BUSYN.
REQ-026 m_axis_tready low SHALL stall the granted requester with all m_axis_* outputs held stable.
REQ-027 Grant latency SHALL be 1 cycle from tvalid in IDLE to the first beat; one IDLE cycle SHALL separate consecutive packets.
REQ-028 A packet SHALL never be interleaved with another packet; arbitration occurs only in IDLE.
REQ-029 Changes to mode0/1 or add_value0/1 during BUSY SHALL affect only the next grant.

Reset
REQ-030 areset high at any edge, including mid-packet, SHALL force IDLE, last_grant = 1 (requester 0 wins the first tie), mode_out = 0, add_value_out = 0, pkt_cnt0 = pkt_cnt1 = 0, grant = 00 and all trdy = 0.
REQ-031 After reset, the remainder of an interrupted packet SHALL be arbitrated as a new packet; no recovery is performed.

Verification
REQ-032 Reset, then s0 and s1 both valid with 2-beat packets continuously -> grant sequence 01,00,10,00,01; pkt_cnt0 = pkt_cnt1 = 1 after the 2nd packet.
REQ-033 s0 packet of 3 beats, mode0 = 2 and add_value0 = 5; change mode0 to 1 after beat 1 -> mode_out = 2 and add_value_out = 5 for all 3 beats.
REQ-034 BUSY1, m_axis_tready low for 4 cycles mid-packet -> m_axis_tdata stable, s1_axis_tready = 0, s0_axis_tready = 0 throughout.
REQ-035 BUSY0, s0_axis_tvalid low for 2 cycles while s1 is valid -> grant stays 01 and s1_axis_tready = 0 until s0 tlast.
REQ-036 areset pulsed on beat 2 of a 4-beat s0 packet -> next cycle grant = 00, m_axis_tvalid = 0 and pkt_cnt0 = 0.
REQ-037 Preload by sending 0xFFFF s0 packets, then one more -> pkt_cnt0 = 0x0000.
